// File: rtl/io_timer_if.sv
// Bus view of the io_timer_irq register window: CPU-side access signals plus
// the registered read data and the two interrupt levels returned to the CPU.
interface io_timer_if;
  logic       cs;
  logic [2:0] addr;
  logic [7:0] data_i;
  logic       write;
  logic       ready;
  logic [7:0] data_o;
  logic       irq;
  logic       nmi;

  modport master (
    output cs, addr, data_i, write, ready,
    input  data_o, irq, nmi
  );

  modport slave (
    input  cs, addr, data_i, write, ready,
    output data_o, irq, nmi
  );
endinterface

// File: rtl/io_timer_irq.sv
// Interval timer with prescaler, auto-reload and a software interrupt bit,
// mapped as an 8-byte register window driving the CPU irq/nmi levels.
module io_timer_irq #(
  parameter logic [7:0] PRESCALE_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  io_timer_if.slave   bus
);

  localparam logic [2:0] A_CTRL  = 3'd0;
  localparam logic [2:0] A_STAT  = 3'd1;
  localparam logic [2:0] A_LLO   = 3'd2;
  localparam logic [2:0] A_LHI   = 3'd3;
  localparam logic [2:0] A_CLO   = 3'd4;
  localparam logic [2:0] A_CHI   = 3'd5;
  localparam logic [2:0] A_PRE   = 3'd6;
  localparam logic [2:0] A_SOFT  = 3'd7;

  logic        en, ar, ien, nsel;
  logic        tf, sp;
  logic [15:0] latch;
  logic [15:0] cnt;
  logic [7:0]  pc;
  logic [7:0]  presc;
  logic [7:0]  snap;
  logic [7:0]  data_o_q;

  logic        acc, wr_acc, rd_acc;
  logic        wr_ctrl, wr_stat, wr_llo, wr_lhi, wr_pre, wr_soft;
  logic        run;
  logic        en_nx;
  logic        tf_set;
  logic [15:0] cnt_nx;
  logic [7:0]  pc_nx;
  logic [7:0]  rd_val;

  assign acc     = bus.cs & bus.ready;
  assign wr_acc  = acc & bus.write;
  assign rd_acc  = acc & ~bus.write;
  assign wr_ctrl = wr_acc && (bus.addr == A_CTRL);
  assign wr_stat = wr_acc && (bus.addr == A_STAT);
  assign wr_llo  = wr_acc && (bus.addr == A_LLO);
  assign wr_lhi  = wr_acc && (bus.addr == A_LHI);
  assign wr_pre  = wr_acc && (bus.addr == A_PRE);
  assign wr_soft = wr_acc && (bus.addr == A_SOFT);

  // A CTRL write that clears EN freezes pc/cnt on that very edge.
  assign run = en & ~(wr_ctrl & ~bus.data_i[0]);

  always_comb begin
    en_nx  = en;
    tf_set = 1'b0;
    cnt_nx = cnt;
    pc_nx  = pc;
    if (wr_ctrl) en_nx = bus.data_i[0];
    if (wr_ctrl && bus.data_i[0] && !en) begin
      cnt_nx = latch;
      pc_nx  = presc;
    end else if (run) begin
      if (pc == 8'd0) begin
        pc_nx = presc;
        if (cnt == 16'd0) begin
          tf_set = 1'b1;
          if (ar) cnt_nx = latch;
          else if (!wr_ctrl) en_nx = 1'b0;
        end else begin
          cnt_nx = cnt - 16'd1;
        end
      end else begin
        pc_nx = pc - 8'd1;
      end
    end else if (wr_lhi && !en) begin
      cnt_nx = {bus.data_i, latch[7:0]};
    end
  end

  always_comb begin
    rd_val = 8'h00;
    case (bus.addr)
      A_CTRL:  rd_val = {4'b0000, nsel, ien, ar, en};
      A_STAT:  rd_val = {6'b000000, sp, tf};
      A_LLO:   rd_val = latch[7:0];
      A_LHI:   rd_val = latch[15:8];
      A_CLO:   rd_val = cnt[7:0];
      A_CHI:   rd_val = snap;
      A_PRE:   rd_val = presc;
      default: rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en       <= 1'b0;
      ar       <= 1'b0;
      ien      <= 1'b0;
      nsel     <= 1'b0;
      tf       <= 1'b0;
      sp       <= 1'b0;
      latch    <= 16'h0000;
      cnt      <= 16'h0000;
      pc       <= 8'h00;
      presc    <= PRESCALE_RESET;
      snap     <= 8'h00;
      data_o_q <= 8'h00;
    end else begin
      en  <= en_nx;
      cnt <= cnt_nx;
      pc  <= pc_nx;
      if (wr_ctrl) {nsel, ien, ar} <= bus.data_i[3:1];
      // Expiry beats a simultaneous W1C so no interrupt is ever lost.
      tf <= tf_set | (tf & ~(wr_stat & bus.data_i[0]));
      sp <= (sp & ~(wr_stat & bus.data_i[1])) | (wr_soft & bus.data_i[0]);
      if (wr_llo) latch[7:0]  <= bus.data_i;
      if (wr_lhi) latch[15:8] <= bus.data_i;
      if (wr_pre) presc       <= bus.data_i;
      if (rd_acc && (bus.addr == A_CLO)) snap <= cnt[15:8];
      if (rd_acc) data_o_q <= rd_val;
    end
  end

  assign bus.data_o = data_o_q;
  assign bus.irq    = (tf & ien & ~nsel) | sp;
  assign bus.nmi    = tf & ien & nsel;

endmodule

// File: tb/tb_io_timer_irq.sv
// Directed bench for io_timer_irq: stimulus pushes expected values into
// queues, a monitor process pops and compares against the DUT outputs.
module tb_io_timer_irq;

  localparam logic [7:0] PRESCALE_RST = 8'h00;

  typedef struct {
    string      name;
    int         kind;   // 0: {irq,nmi} level, 1: data_o
    logic [7:0] exp;
  } item_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  io_timer_if bus ();

  io_timer_irq #(.PRESCALE_RESET(PRESCALE_RST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  item_t rd_q[$];
  item_t lvl_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  logic  rd_pend = 1'b0;

  task automatic compare(input item_t it);
    logic [7:0] act;
    act = (it.kind == 0) ? {6'b000000, bus.irq, bus.nmi} : bus.data_o;
    n_vec++;
    if (act !== it.exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", it.name, act, it.exp, $time);
    end
  endtask

  // Monitor: a read accepted at a rising edge is presented on data_o by the
  // following falling edge; level checks are taken at the same falling edge.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      rd_pend = bus.cs & bus.ready & ~bus.write & ~reset;
      @(negedge clk);
      if (rd_pend) begin
        if (rd_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_read: got %02h, expected no read", bus.data_o);
        end else begin
          it = rd_q.pop_front();
          compare(it);
        end
      end
      while (lvl_q.size() > 0) begin
        it = lvl_q.pop_front();
        compare(it);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.ready = 1'b1;
    bus.addr = a;  bus.data_i = d;
    step(1);
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string nm);
    bus.cs = 1'b1; bus.write = 1'b0; bus.ready = 1'b1; bus.addr = a;
    rd_q.push_back('{nm, 1, e});
    step(1);
    bus.cs = 1'b0;
  endtask

  task automatic chk_lvl(input logic irq_e, input logic nmi_e, input string nm);
    lvl_q.push_back('{nm, 0, {6'b000000, irq_e, nmi_e}});
  endtask

  task automatic chk_do(input logic [7:0] e, input string nm);
    lvl_q.push_back('{nm, 1, e});
  endtask

  initial begin
    // Reset held two clocks while the CPU attempts a PRESCALE write
    bus.cs = 1'b1; bus.write = 1'b1; bus.ready = 1'b1;
    bus.addr = 3'd6; bus.data_i = 8'hAA;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    bus.cs = 1'b0; bus.write = 1'b0;
    chk_lvl(1'b0, 1'b0, "rst_irq_nmi");
    chk_do(8'h00, "rst_data_o");
    rd(3'd6, PRESCALE_RST, "rst_prescale");

    // Periodic: LATCH=3, P=1 -> expiry every 8 clocks
    wr(3'd2, 8'h03);
    wr(3'd3, 8'h00);
    wr(3'd6, 8'h01);
    rd(3'd6, 8'h01, "prescale_rb");
    wr(3'd0, 8'h07);
    step(7);
    chk_lvl(1'b0, 1'b0, "per_before1");
    step(1);
    chk_lvl(1'b1, 1'b0, "per_expiry1");
    wr(3'd1, 8'h01);
    chk_lvl(1'b0, 1'b0, "per_w1c");
    step(6);
    chk_lvl(1'b0, 1'b0, "per_before2");
    step(1);
    chk_lvl(1'b1, 1'b0, "per_expiry2");

    // Race: W1C lands on the next expiry edge
    step(7);
    wr(3'd1, 8'h01);
    chk_lvl(1'b1, 1'b0, "race_irq");
    rd(3'd1, 8'h01, "race_status");

    // One-shot
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h01);
    wr(3'd0, 8'h05);
    step(7);
    chk_lvl(1'b0, 1'b0, "os_before");
    step(1);
    chk_lvl(1'b1, 1'b0, "os_expiry");
    rd(3'd0, 8'h04, "os_ctrl");
    wr(3'd1, 8'h01);
    chk_lvl(1'b0, 1'b0, "os_cleared");
    step(40);
    chk_lvl(1'b0, 1'b0, "os_quiet");
    rd(3'd1, 8'h00, "os_status");

    // NMI routing plus software IRQ
    wr(3'd0, 8'h0F);
    step(7);
    chk_lvl(1'b0, 1'b0, "nmi_before");
    step(1);
    chk_lvl(1'b0, 1'b1, "nmi_expiry");
    wr(3'd7, 8'h01);
    chk_lvl(1'b1, 1'b1, "nmi_soft");
    rd(3'd1, 8'h03, "nmi_status");
    rd(3'd7, 8'h00, "soft_read");
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h03);
    chk_lvl(1'b0, 1'b0, "nmi_cleared");

    // Ready stall: no write, no read, data_o holds
    rd(3'd2, 8'h03, "latch_lo_rb");
    bus.cs = 1'b1; bus.write = 1'b1; bus.ready = 1'b0;
    bus.addr = 3'd0; bus.data_i = 8'h01;
    step(5);
    bus.write = 1'b0; bus.addr = 3'd6;
    step(2);
    chk_do(8'h03, "stall_hold");
    bus.cs = 1'b0; bus.ready = 1'b1;
    rd(3'd0, 8'h00, "stall_ctrl");

    // Count snapshot: LATCH=0x0105, P=0, running with auto-reload
    wr(3'd2, 8'h05);
    wr(3'd3, 8'h01);
    wr(3'd6, 8'h00);
    wr(3'd0, 8'h03);
    rd(3'd4, 8'h05, "cnt_lo");
    step(9);
    rd(3'd5, 8'h01, "cnt_hi_snap");
    rd(3'd4, 8'hFA, "cnt_lo_live");

    step(3);
    if (rd_q.size() != 0 || lvl_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending checks, expected 0", rd_q.size() + lvl_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/io_timer_irq.md
# io_timer_irq

Memory-mapped interval timer and interrupt source for the 4510 CPU bus. It decodes an 8-byte register window and drives the CPU `irq` and `nmi` inputs. It replaces the raw io-port bits that feed those lines in the bench, so directed code can schedule periodic or one-shot interrupts. It uses the same bus view as the hypervisor controller: chip-select from `address_next`, `write_next`/`data_o_next` qualified by `ready`, and a registered read path.

## Interface
- `PRESCALE_RESET`, 8'h00: reset value of the PRESCALE register.
- `clk`, in, 1: system clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `cs`, in, 1: register window selected; decoded externally from `cpu_address_next`.
- `addr`, in, 3: register offset, taken from `cpu_address_next[2:0]`.
- `data_i`, in, 8: write data, taken from CPU `data_o_next`.
- `write`, in, 1: CPU `write_next`.
- `ready`, in, 1: bus ready; an access is accepted only on cycles where `cs & ready` is high.
- `data_o`, out, 8: registered read data.
- `irq`, out, 1: level interrupt request to the CPU.
- `nmi`, out, 1: level NMI request to the CPU.

## Operation
Register map:
- 0 CTRL, R/W:
  - bit0 EN: timer enable.
  - bit1 AR: auto-reload.
  - bit2 IEN: timer interrupt enable.
  - bit3 NSEL: route the timer interrupt to `nmi` instead of `irq`.
  - bits 7:4 read as 0.
- 1 STATUS: bit0 TF (timer expired), bit1 SP (software IRQ pending). Write-1-to-clear. Other bits read as 0.
- 2/3 LATCH_LO/HI, R/W: 16-bit reload value.
- 4/5 COUNT_LO/HI, read-only:
  - An accepted read of COUNT_LO returns the live low byte and snapshots the live high byte.
  - COUNT_HI returns that snapshot.
- 6 PRESCALE, R/W: 8-bit value P.
- 7 SOFT, write-only: bit0=1 sets SP. Reads as 00.

Accepted write (`cs & ready & write`): the addressed register updates at the clock edge.

Accepted read (`cs & ready & !write`): `data_o` loads the addressed value at the clock edge. Otherwise `data_o` holds its value.

Timer behaviour:
- Prescaler counter `pc` (8-bit) and count `cnt` (16-bit).
- When EN=1, on each edge:
  - If `pc`==0, `pc`←P and a tick occurs.
  - Otherwise `pc`←`pc`−1.
- On a tick:
  - If `cnt`==0: TF←1. Then `cnt`←LATCH if AR=1; otherwise EN←0 and `cnt` stays 0.
  - Otherwise `cnt`←`cnt`−1.
- Writing CTRL with EN going 0→1 loads `cnt`←LATCH and `pc`←P on that edge, with no tick on that edge.
- Writing LATCH_HI while EN=0 also loads `cnt`←{LATCH_HI new, LATCH_LO}.
- Expiry period is (N+1)·(P+1) clocks for LATCH=N.

Outputs:
- `irq` = (TF & IEN & !NSEL) | SP.
- `nmi` = TF & IEN & NSEL.
- Both are combinational from registers, with no bus-input paths.

Boundary rules:
- TF set by expiry and a W1C on the same edge: the set wins and TF stays 1.
- A SOFT write and a STATUS W1C of bit1 on the same edge: impossible, since only one access per edge is possible.
- A CTRL write clearing EN freezes `pc` and `cnt` on that edge.
- A one-shot expiry and a CTRL write on the same edge: the written EN value wins.
- `cnt` wraps only via reload; no decrement below 0.

## Timing
- Reset (synchronous): CTRL, STATUS, LATCH, snapshot, `cnt`, `pc` = 0; PRESCALE = `PRESCALE_RESET`; `data_o`=00; `irq`=`nmi`=0.
- Reset mid-count aborts the count immediately. Reset has priority over any simultaneous access.
- Read latency: data is on `data_o` from the edge that accepts the access, one cycle after `cs` is presented. This matches the registered `bus_device` mux.
- Write latency: the register takes the new value at the accepting edge. Interrupt outputs change in the same cycle after that edge.
- `ready` low: no side effects. There is no write, no snapshot, and `data_o` holds. The timer keeps running independently of `ready`.

## Test plan
- Reset: hold `reset` for 2 clocks with `cs` active. Required: `irq`=`nmi`=0 and `data_o`=00; a subsequent read of PRESCALE returns `PRESCALE_RESET`.
- Periodic: write LATCH_LO=03, LATCH_HI=00, PRESCALE=01, CTRL=07. Required: `irq` rises 8 clocks after the CTRL-accepting edge. A STATUS write of 01 drops it. It rises again 8 clocks after the previous expiry.
- One-shot: configure as in the periodic test, then write CTRL=05. Required: a single expiry at +8; the CTRL read then returns 04; no further TF after a STATUS clear over 40 clocks.
- NMI routing: write CTRL=0F. Required: on expiry `nmi`=1 and `irq`=0. A SOFT write of 01 raises `irq` while `nmi` stays 1.
- Race: issue a STATUS W1C of 01 on the exact expiry edge. Required: TF remains 1 and `irq` stays high.
- Ready stall: hold `ready` low while CPU drives `cs`, `write`, CTRL=01 for 5 clocks. Required: CTRL is unchanged. Then, with the count running, a COUNT_LO read followed 10 clocks later by a COUNT_HI read returns the high byte at snapshot time.
